// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: shares one GMII transmit framer among NREQ frame sources.
// Whole-frame round-robin grants, frame-level lock, minimum inter-frame gap
// and a hard maximum frame length with forced abort. GTX_CLK domain only.
module tx_frame_arbiter #(
  parameter int OCT        = 8,
  parameter int NREQ       = 4,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1518
) (
  input  logic                GTX_CLK,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  input  logic [NREQ-1:0]     src_valid,
  input  logic [NREQ*OCT-1:0] src_data,
  input  logic [NREQ-1:0]     src_last,
  output logic [NREQ-1:0]     src_ready,
  output logic                out_valid,
  output logic [OCT-1:0]      out_data,
  output logic                out_last,
  output logic                out_err,
  input  logic                out_ready,
  output logic                busy,
  output logic [15:0]         abort_cnt
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IFGW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    IFG   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [IDXW-1:0]   sel, sel_nxt;
  logic [IDXW-1:0]   rr_ptr, rr_nxt;
  logic [15:0]       byte_cnt, byte_nxt;
  logic [IFGW-1:0]   ifg_cnt, ifg_nxt;
  logic [15:0]       abort_nxt;

  logic [IDXW-1:0]   pick;
  logic              pick_ok;
  logic [NREQ-1:0]   pick_onehot;

  logic              in_grant;
  logic              cur_valid;
  logic              cur_last;
  logic [OCT-1:0]    cur_data;
  logic              xfer;
  logic              at_max;
  logic              abort_hit;

  // Round-robin search starting at rr_ptr; first requester found wins.
  always_comb begin
    int unsigned idx;
    pick        = '0;
    pick_ok     = 1'b0;
    pick_onehot = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!pick_ok && req[idx]) begin
        pick    = IDXW'(idx);
        pick_ok = 1'b1;
      end
    end
    pick_onehot[pick] = 1'b1;
  end

  // Granted-source byte path and frame-end detection.
  always_comb begin
    in_grant  = (state == GRANT);
    cur_valid = src_valid[sel];
    cur_last  = src_last[sel];
    cur_data  = src_data[32'(sel)*OCT +: OCT];
    xfer      = in_grant & cur_valid & out_ready;
    at_max    = (byte_cnt == 16'(MAX_LEN - 1));
    // Abort flag depends only on the presented byte so it is stable while
    // the framer back-pressures; it takes effect on the actual transfer.
    abort_hit = in_grant & cur_valid & ~cur_last & at_max;
  end

  // Output drive; nothing reaches the framer outside GRANT.
  always_comb begin
    out_valid = in_grant & cur_valid;
    out_data  = in_grant ? cur_data : '0;
    out_last  = in_grant & cur_valid & (cur_last | abort_hit);
    out_err   = abort_hit;
    src_ready = gnt & {NREQ{in_grant & out_ready}};
    busy      = (state != IDLE);
  end

  // Next-state logic for grant, frame counting, abort accounting and gap.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    rr_nxt    = rr_ptr;
    byte_nxt  = byte_cnt;
    ifg_nxt   = ifg_cnt;
    abort_nxt = abort_cnt;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          gnt_nxt   = pick_onehot;
          sel_nxt   = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (cur_last || at_max) begin
            gnt_nxt   = '0;
            rr_nxt    = (sel == IDXW'(NREQ - 1)) ? '0 : sel + 1'b1;
            byte_nxt  = '0;
            ifg_nxt   = '0;
            state_nxt = IFG;
            if (!cur_last && abort_cnt != 16'hFFFF) begin
              abort_nxt = abort_cnt + 16'd1;
            end
          end else begin
            byte_nxt = byte_cnt + 16'd1;
          end
        end
      end
      IFG: begin
        if (ifg_cnt == IFGW'(IFG_CYCLES - 1)) begin
          ifg_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          ifg_nxt = ifg_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge GTX_CLK) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      ifg_cnt   <= '0;
      abort_cnt <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      sel       <= sel_nxt;
      rr_ptr    <= rr_nxt;
      byte_cnt  <= byte_nxt;
      ifg_cnt   <= ifg_nxt;
      abort_cnt <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: randomized and directed stimulus for tx_frame_arbiter,
// checked cycle by cycle against a frame/edge-level reference model.
module tb_tx_frame_arbiter;

  localparam int NREQ = 4;
  localparam int OCT  = 8;
  localparam int IFG  = 12;
  localparam int MAXL = 1518;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     src_valid;
  logic [NREQ*OCT-1:0] src_data;
  logic [NREQ-1:0]     src_last;
  logic [NREQ-1:0]     src_ready;
  logic                out_valid;
  logic [OCT-1:0]      out_data;
  logic                out_last;
  logic                out_err;
  logic                out_ready;
  logic                busy;
  logic [15:0]         abort_cnt;

  always #5 clk = ~clk;

  tx_frame_arbiter #(
    .OCT(OCT), .NREQ(NREQ), .IFG_CYCLES(IFG), .MAX_LEN(MAXL)
  ) dut (
    .GTX_CLK(clk), .rst(rst), .req(req), .gnt(gnt),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_err(out_err), .out_ready(out_ready),
    .busy(busy), .abort_cnt(abort_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Model: owner of the framer, next round-robin start, earliest edge at
  // which a new grant may appear, bytes in current frame, expected aborts.
  int cyc, owner, rr, eligible, cnt, exp_abort;
  int active[NREQ], len[NREQ], pos[NREQ], fno[NREQ];
  int nolast[NREQ], hold[NREQ], waitc[NREQ];
  bit autogen;
  int lmin, lmax, vpct, rmode, vblock;
  bit rst_pulse;
  int gq[$];
  logic [NREQ-1:0] prev_gnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(int i);
    return 8'(i * 64 + fno[i] * 13 + pos[i]);
  endfunction

  task automatic start_frame(int i, int l, int nl, int h);
    active[i] = 1; len[i] = l; pos[i] = 0; nolast[i] = nl; hold[i] = h;
  endtask

  task automatic end_frame(int i);
    active[i] = 0; fno[i]++; waitc[i] = $urandom_range(0, 6);
  endtask

  function automatic bit any_active();
    for (int i = 0; i < NREQ; i++) if (active[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check the
  // combinational path, then advance the model across the coming edge.
  task automatic step();
    logic [NREQ-1:0] exp_gnt, exp_rdy;
    bit ov, xfer, lastb, abort_c;
    @(negedge clk);
    exp_gnt = '0;
    if (owner >= 0) exp_gnt[owner] = 1'b1;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("busy", 32'(busy), 32'((owner >= 0) || (cyc < eligible)));
    check("abort_cnt", 32'(abort_cnt), 32'(exp_abort));
    if (gnt != '0 && prev_gnt == '0)
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gq.push_back(i);
    prev_gnt = gnt;

    for (int i = 0; i < NREQ; i++)
      if (active[i] == 0 && autogen) begin
        if (waitc[i] > 0) waitc[i]--;
        else start_frame(i, $urandom_range(lmin, lmax), 0, $urandom_range(0, 1));
      end

    rst = rst_pulse;
    for (int i = 0; i < NREQ; i++) begin
      req[i]       = (active[i] != 0) && (owner != i || hold[i] != 0);
      src_valid[i] = (active[i] != 0) && (vblock == 0) && ($urandom_range(0, 99) < vpct);
      src_data[i*OCT +: OCT] = byte_of(i);
      src_last[i]  = (active[i] != 0) && (nolast[i] == 0) && (pos[i] == len[i] - 1);
    end
    if (vblock > 0) vblock--;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 2 == 0);
      default: out_ready = ($urandom_range(0, 99) < 60);
    endcase
    #1;

    ov      = (owner >= 0) && src_valid[owner];
    xfer    = ov && out_ready;
    lastb   = ov && src_last[owner];
    abort_c = ov && !src_last[owner] && (cnt == MAXL - 1);
    exp_rdy = '0;
    if (owner >= 0 && out_ready) exp_rdy[owner] = 1'b1;
    check("out_valid", 32'(out_valid), 32'(ov));
    check("src_ready", 32'(src_ready), 32'(exp_rdy));
    check("out_err", 32'(out_err), 32'(abort_c));
    if (ov) begin
      check("out_data", 32'(out_data), 32'(byte_of(owner)));
      check("out_last", 32'(out_last), 32'(lastb || abort_c));
    end

    if (rst_pulse) begin
      if (owner >= 0) end_frame(owner);
      owner = -1; rr = 0; exp_abort = 0; cnt = 0; eligible = cyc + 1;
      rst_pulse = 0;
    end else if (owner >= 0) begin
      if (xfer) begin
        pos[owner]++;
        cnt++;
        if (lastb || cnt == MAXL) begin
          if (!lastb && exp_abort < 16'hFFFF) exp_abort++;
          end_frame(owner);
          rr = (owner + 1) % NREQ;
          owner = -1;
          cnt = 0;
          eligible = cyc + IFG + 1;
        end
      end
    end else if (cyc >= eligible && req != '0) begin
      for (int k = 0; k < NREQ; k++)
        if (owner < 0 && req[(rr + k) % NREQ]) owner = (rr + k) % NREQ;
    end
    cyc++;
  endtask

  task automatic run_idle(int maxc);
    int n;
    n = 0;
    while ((any_active() || owner >= 0 || cyc < eligible) && n < maxc) begin
      step();
      n++;
    end
    check("idle_reached", 32'(n < maxc), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '0; src_valid = '0; src_data = '0; src_last = '0; out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      active[i] = 0; len[i] = 0; pos[i] = 0; fno[i] = 0;
      nolast[i] = 0; hold[i] = 1; waitc[i] = 0;
    end
    autogen = 0; lmin = 1; lmax = 10; vpct = 100; rmode = 0; vblock = 0; rst_pulse = 0;
    owner = -1; rr = 0; cnt = 0; exp_abort = 0; cyc = 0; eligible = 0; prev_gnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_abort", 32'(abort_cnt), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);

    // Single 64-byte frame from source 0.
    gq.delete();
    start_frame(0, 64, 0, 1);
    run_idle(200);
    check("t1_order_n", 32'(gq.size()), 32'd1);
    if (gq.size() == 1) check("t1_order0", 32'(gq[0]), 32'd0);

    // Fresh reset, then all four request 10-byte frames; source 0 re-requests.
    rst_pulse = 1;
    step();
    gq.delete();
    for (int i = 0; i < NREQ; i++) start_frame(i, 10, 0, 1);
    n = 0;
    while (active[0] != 0 && n < 200) begin step(); n++; end
    check("t2_src0_done", 32'(n < 200), 32'd1);
    start_frame(0, 10, 0, 1);
    run_idle(400);
    check("t2_order_n", 32'(gq.size()), 32'd5);
    if (gq.size() == 5) begin
      check("t2_order0", 32'(gq[0]), 32'd0);
      check("t2_order1", 32'(gq[1]), 32'd1);
      check("t2_order2", 32'(gq[2]), 32'd2);
      check("t2_order3", 32'(gq[3]), 32'd3);
      check("t2_order4", 32'(gq[4]), 32'd0);
    end

    // Oversized frame from source 2 is aborted at MAX_LEN; source 3 next.
    gq.delete();
    start_frame(2, 1600, 1, 1);
    start_frame(3, 10, 0, 1);
    run_idle(2000);
    check("t3_abort_cnt", 32'(abort_cnt), 32'd1);
    check("t3_order_n", 32'(gq.size()), 32'd2);
    if (gq.size() == 2) begin
      check("t3_order0", 32'(gq[0]), 32'd2);
      check("t3_order1", 32'(gq[1]), 32'd3);
    end

    // Exactly MAX_LEN bytes with last on the final byte is not an abort.
    start_frame(0, MAXL, 0, 1);
    run_idle(2000);
    check("maxlen_exact_abort_cnt", 32'(abort_cnt), 32'd1);

    // Toggling out_ready and a 5-cycle valid gap inside a frame.
    rmode = 1;
    start_frame(1, 30, 0, 1);
    n = 0;
    while (pos[1] < 3 && n < 100) begin step(); n++; end
    vblock = 5;
    run_idle(300);
    rmode = 0;

    // Reset mid-frame at byte 20 with rr_ptr parked away from zero.
    start_frame(2, 5, 0, 1);
    run_idle(100);
    start_frame(1, 64, 0, 1);
    n = 0;
    while (!(owner == 1 && cnt == 20) && n < 200) begin step(); n++; end
    check("t5_reached_byte20", 32'(n < 200), 32'd1);
    rst_pulse = 1;
    step();
    step();
    check("t5_gnt_after_rst", 32'(gnt), 32'd0);
    check("t5_busy_after_rst", 32'(busy), 32'd0);
    gq.delete();
    start_frame(3, 5, 0, 1);
    start_frame(0, 5, 0, 1);
    run_idle(200);
    check("t5_rr_zero", 32'(gq.size() > 0 ? gq[0] : -1), 32'd0);

    // Requester drops req while granted; frame still runs to its last byte.
    start_frame(1, 20, 0, 0);
    step();
    start_frame(2, 6, 0, 1);
    run_idle(200);

    // Randomized traffic.
    autogen = 1; lmin = 1; lmax = 40; vpct = 75; rmode = 2;
    repeat (2000) step();
    autogen = 0;
    run_idle(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
